imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Responder (memory side) of the core's instruction-fetch interface: imem_ready/imem_addr request in, imem_valid/imem_rresp/imem_rdata response out.
- Serves halfword-aligned fetch addresses so the compressed-instruction decoder always sees the instruction in rdata[15:0].
- Fetches from a word-wide synchronous SRAM with 1-cycle read latency.
- Assembles instructions that straddle two SRAM words, and flags illegal fetches.

Parameters:
- AW, 14, SRAM word-address width (capacity 2^AW words, byte range 0 .. 2^(AW+2)-1).

Ports:
- clk  in  1  clock
- resetb  in  1  reset
- imem_ready  in  1  fetch request strobe from core
- imem_addr  in  32  fetch byte address, sampled only on acceptance
- imem_valid  out  1  one-cycle response strobe
- imem_rresp  out  1  1 = OK, 0 = fetch error
- imem_rdata  out  32  instruction window starting at the fetch address
- mem_ce  out  1  SRAM read enable
- mem_addr  out  AW  SRAM word address
- mem_rdata  in  32  SRAM data, valid the cycle after mem_ce

Behaviour:
- Clock and reset (already decided): one clock, clk; reset resetb is asynchronous and active-low.
- Reset values: imem_valid=0, imem_rresp=0, imem_rdata=0, mem_ce=0, mem_addr=0, state IDLE.
- Reset mid-operation drops the transaction; no response is issued.
- Registered outputs: imem_valid, imem_rresp, imem_rdata.
- Combinational outputs: mem_ce and mem_addr, decoded from state, imem_addr and mem_rdata.
- States: IDLE, RD0, RD1.
- Acceptance:
  - A request is accepted only in IDLE while imem_ready=1.
  - imem_ready in RD0/RD1 is ignored; the core holds it until imem_valid.
  - On acceptance: W = imem_addr[AW+1:2] and h = imem_addr[1] are latched.
- Illegal request: imem_addr[0]=1 or imem_addr[31:AW+2]!=0.
  - No SRAM access; stay in IDLE.
  - Next cycle: imem_valid=1, imem_rresp=0, imem_rdata=0.
- Legal request (cycle T): mem_ce=1, mem_addr=W; go to RD0.
- RD0 (T+1), mem_rdata = word W:
  - h=0: capture word W; IDLE; at T+2 imem_valid=1, rresp=1, rdata=word W.
  - h=1, W[17:16]!=2'b11 (compressed): capture {16'h0, W[31:16]}; IDLE; response at T+2.
  - h=1, W[17:16]==2'b11, W = 2^AW-1: no further read; response at T+2 with rresp=0, rdata=0.
  - Otherwise: mem_ce=1, mem_addr=W+1; save W[31:16]; go to RD1.
- RD1 (T+2): capture {mem_rdata[15:0], saved}; IDLE; response at T+3 with rresp=1.
- Response strobe:
  - imem_valid is high exactly one cycle per accepted request; the FSM is already in IDLE during that cycle.
  - A new request is accepted in the same cycle as imem_valid (back-to-back).
  - Aligned throughput: one fetch per 2 cycles.
- imem_rdata holds its last value when imem_valid=0.
- mem_ce=0 in every cycle not listed above.

Test Plan:
- AW=4, SRAM[0]=32'h00500093, req addr 0x0 at T -> mem_ce at T (addr 0); imem_valid/rresp=1, rdata=32'h00500093 at T+2.
- SRAM[1]=32'h4505_0001, addr 0x6 -> single SRAM read; rdata=32'h0000_4505 at T+2; mem_ce=0 at T+1.
- SRAM[1]=32'h0093_0001, SRAM[2]=32'h0000_0050, addr 0x6 -> reads word 1 then word 2; rdata=32'h0050_0093 at T+3.
- Addr 0x3 and addr 0x40 (out of range) -> no mem_ce; valid at T+1 with rresp=0, rdata=0. Addr 0x3E with SRAM[15][17:16]=2'b11 -> rresp=0 at T+2.
- Back-to-back: ready held with addr 0x0, 0x4, 0x8 -> valid at T+2, T+4, T+6; the second request is accepted in the T+2 valid cycle.
- resetb low at T+2 of a straddling fetch -> no valid; all outputs 0; the next request after reset completes normally.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Memory-side responder for the instruction-fetch port: serves halfword-aligned
// fetches out of a word-wide 1-cycle-latency SRAM, joining instructions that straddle two words.
module imem_fetch_responder #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          imem_ready,
  input  logic [31:0]   imem_addr,
  output logic          imem_valid,
  output logic          imem_rresp,
  output logic [31:0]   imem_rdata,
  output logic          mem_ce,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  // Handshake: a request is taken when imem_ready=1 while the FSM is in IDLE;
  // imem_addr is sampled only then. Exactly one imem_valid pulse answers each
  // taken request, and a new request may be taken in that same pulse cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [AW-1:0] word_q;
  logic          half_q;
  logic [15:0]   saved_q;

  logic          req_legal;
  logic          accept;
  logic          save_en;
  logic          rsp_set;
  logic          rsp_ok;
  logic [31:0]   rsp_data;

  assign req_legal = (imem_addr[0] == 1'b0) && (imem_addr[31:AW+2] == '0);

  always_comb begin
    state_d  = state_q;
    mem_ce   = 1'b0;
    mem_addr = '0;
    accept   = 1'b0;
    save_en  = 1'b0;
    rsp_set  = 1'b0;
    rsp_ok   = 1'b0;
    rsp_data = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (imem_ready) begin
          accept = 1'b1;
          if (req_legal) begin
            mem_ce   = 1'b1;
            mem_addr = imem_addr[AW+1:2];
            state_d  = RD0;
          end else begin
            // Illegal fetch: answer with an error next cycle, no SRAM access.
            rsp_set = 1'b1;
          end
        end
      end

      RD0: begin
        state_d = IDLE;
        if (!half_q) begin
          rsp_set  = 1'b1;
          rsp_ok   = 1'b1;
          rsp_data = mem_rdata;
        end else if (mem_rdata[17:16] != 2'b11) begin
          // Compressed instruction in the upper halfword: one read suffices.
          rsp_set  = 1'b1;
          rsp_ok   = 1'b1;
          rsp_data = {16'h0, mem_rdata[31:16]};
        end else if (word_q == {AW{1'b1}}) begin
          // 32-bit instruction would run past the last SRAM word.
          rsp_set  = 1'b1;
          rsp_ok   = 1'b0;
          rsp_data = 32'h0;
        end else begin
          mem_ce   = 1'b1;
          mem_addr = word_q + 1'b1;
          save_en  = 1'b1;
          state_d  = RD1;
        end
      end

      RD1: begin
        state_d  = IDLE;
        rsp_set  = 1'b1;
        rsp_ok   = 1'b1;
        rsp_data = {mem_rdata[15:0], saved_q};
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      word_q  <= '0;
      half_q  <= 1'b0;
      saved_q <= 16'h0;
    end else begin
      if (accept) begin
        word_q <= imem_addr[AW+1:2];
        half_q <= imem_addr[1];
      end
      if (save_en) begin
        saved_q <= mem_rdata[31:16];
      end
    end
  end

  // imem_rdata/imem_rresp only move on a response so they hold between strobes.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      imem_valid <= 1'b0;
      imem_rresp <= 1'b0;
      imem_rdata <= 32'h0;
    end else begin
      imem_valid <= rsp_set;
      if (rsp_set) begin
        imem_rresp <= rsp_ok;
        imem_rdata <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder (AW=4): directed vector table, hand-written
// back-to-back and reset sequences, then random fetches against a reference model.
module tb_imem_fetch_responder;

  localparam int AW = 4;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          resetb;
  logic          imem_ready;
  logic [31:0]   imem_addr;
  logic          imem_valid;
  logic          imem_rresp;
  logic [31:0]   imem_rdata;
  logic          mem_ce;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  logic [31:0]   sram [NW];

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch_responder #(.AW(AW)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rresp (imem_rresp),
    .imem_rdata (imem_rdata),
    .mem_ce     (mem_ce),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous SRAM, 1-cycle read latency
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_ce) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what the fetch returns, computed from the byte address and memory image.
  function automatic void model(input logic [31:0] addr, output int lat, output logic ok,
                                output logic [31:0] data, output int reads);
    int unsigned wi;
    logic [15:0] lo;
    if (addr[0] || addr >= 32'(NW * 4)) begin
      lat = 1; ok = 1'b0; data = 32'h0; reads = 0;
      return;
    end
    wi = addr >> 2;
    lo = addr[1] ? sram[wi][31:16] : sram[wi][15:0];
    if (!addr[1]) begin
      lat = 2; ok = 1'b1; data = sram[wi]; reads = 1;
    end else if (lo[1:0] != 2'b11) begin
      lat = 2; ok = 1'b1; data = {16'h0, lo}; reads = 1;
    end else if (wi == NW - 1) begin
      lat = 2; ok = 1'b0; data = 32'h0; reads = 1;
    end else begin
      lat = 3; ok = 1'b1; data = {sram[wi + 1][15:0], lo}; reads = 2;
    end
  endfunction

  // Driver: issue one request at a negedge, return at the negedge where imem_valid is seen.
  task automatic do_request(input logic [31:0] addr, input string name);
    int e_lat, e_reads, lat, reads;
    logic e_ok;
    logic [31:0] e_data;
    logic legal;
    model(addr, e_lat, e_ok, e_data, e_reads);
    legal = (e_lat != 1);
    imem_addr  = addr;
    imem_ready = 1'b1;
    #1;
    check({name, " mem_ce@T"}, 32'(mem_ce), 32'(legal));
    if (legal) check({name, " mem_addr@T"}, 32'(mem_addr), addr >> 2);
    reads = int'(mem_ce);
    @(negedge clk);
    imem_ready = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (imem_valid) begin
        lat = c;
        break;
      end
      reads += int'(mem_ce);
      if (mem_ce) check({name, " mem_addr next"}, 32'(mem_addr), (addr >> 2) + 1);
      @(negedge clk);
    end
    if (lat == 0) begin
      check({name, " valid timeout"}, 32'd99, 32'(e_lat));
    end else begin
      check({name, " latency"}, 32'(lat), 32'(e_lat));
      check({name, " rresp"}, 32'(imem_rresp), 32'(e_ok));
      check({name, " rdata"}, imem_rdata, e_data);
      check({name, " sram reads"}, 32'(reads), 32'(e_reads));
    end
  endtask

  typedef struct {
    string       name;
    int          pre_idx;
    logic [31:0] pre_val;
    logic [31:0] addr;
    int          lat;
    logic        ok;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] held;
    logic [31:0] a;
    int e_lat, e_reads;
    logic e_ok;
    logic [31:0] e_data;

    for (int i = 0; i < NW; i++) sram[i] = 32'h0;
    sram[2] = 32'h0000_0050;

    vecs[0] = '{"aligned w0",   0,  32'h0050_0093, 32'h0000_0000, 2, 1'b1, 32'h0050_0093};
    vecs[1] = '{"compressed",   1,  32'h4505_0001, 32'h0000_0006, 2, 1'b1, 32'h0000_4505};
    vecs[2] = '{"straddle",     1,  32'h0093_0001, 32'h0000_0006, 3, 1'b1, 32'h0050_0093};
    vecs[3] = '{"odd addr",     -1, 32'h0,         32'h0000_0003, 1, 1'b0, 32'h0};
    vecs[4] = '{"out of range", -1, 32'h0,         32'h0000_0040, 1, 1'b0, 32'h0};
    vecs[5] = '{"last word",    15, 32'h0003_0000, 32'h0000_003E, 2, 1'b0, 32'h0};
    vecs[6] = '{"high addr",    -1, 32'h0,         32'h8000_0000, 1, 1'b0, 32'h0};

    resetb     = 1'b0;
    imem_ready = 1'b0;
    imem_addr  = 32'h0;
    repeat (2) @(negedge clk);
    check("reset valid", 32'(imem_valid), 32'h0);
    check("reset rresp", 32'(imem_rresp), 32'h0);
    check("reset rdata", imem_rdata, 32'h0);
    check("reset mem_ce", 32'(mem_ce), 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    resetb = 1'b1;
    @(negedge clk);

    // Table: the model must agree with the hand-derived expectation, then the DUT with both.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_idx >= 0) sram[vecs[i].pre_idx] = vecs[i].pre_val;
      model(vecs[i].addr, e_lat, e_ok, e_data, e_reads);
      check({vecs[i].name, " model lat"}, 32'(e_lat), 32'(vecs[i].lat));
      check({vecs[i].name, " model data"}, e_data, vecs[i].data);
      do_request(vecs[i].addr, vecs[i].name);
      held = imem_rdata;
      @(negedge clk);
      check({vecs[i].name, " valid one cycle"}, 32'(imem_valid), 32'h0);
      check({vecs[i].name, " rdata held"}, imem_rdata, held);
    end

    // Back-to-back: ready held, new address accepted in each valid cycle.
    sram[0] = 32'h1111_0001;
    sram[1] = 32'h2222_0002;
    sram[2] = 32'h3333_0003;
    imem_ready = 1'b1;
    imem_addr  = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b valid k%0d", k), 32'(imem_valid), 32'((k % 2) == 0));
      if (k % 2 == 0) begin
        check($sformatf("b2b rdata k%0d", k), imem_rdata, sram[k / 2 - 1]);
        imem_addr = 32'(k * 2);
      end
      if (k == 6) imem_ready = 1'b0;
    end
    @(negedge clk);
    check("b2b tail valid", 32'(imem_valid), 32'h0);

    // Reset during the second read of a straddling fetch drops it.
    sram[1] = 32'h0093_0001;
    sram[2] = 32'h0000_0050;
    imem_addr  = 32'h6;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check("midrst valid", 32'(imem_valid), 32'h0);
    check("midrst rdata", imem_rdata, 32'h0);
    check("midrst rresp", 32'(imem_rresp), 32'h0);
    check("midrst mem_ce", 32'(mem_ce), 32'h0);
    check("midrst mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst no valid", 32'(imem_valid), 32'h0);
    end
    do_request(32'h6, "after reset");
    @(negedge clk);

    // Random fetches against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NW; i++) sram[i] = $urandom();
      end
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 63)) | 32'h1;
        1:       a = $urandom() | 32'h40;
        2:       a = 32'h3E;
        default: a = 32'($urandom_range(0, 31)) << 1;
      endcase
      do_request(a, $sformatf("rand%0d a=%0h", n, a));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
